char_motion_ctrl: RTL
=====================

CHAR_MOTION_CTRL -- requirements
Module: char_motion_ctrl

Interface
REQ-001 SHALL provide parameter COORD_W, 10, width of the position coordinates.
REQ-002 SHALL provide parameter TICK_DIV, 65000, clk cycles per movement tick.
REQ-003 SHALL provide parameter START_X, 355, and START_Y, 454, home position.
REQ-004 SHALL provide parameter JUMP_STEPS, 80, ticks per jump (even, >=2).
REQ-005 SHALL provide parameter JUMP_DX, 1, and JUMP_DY, 2, per-tick jump displacement.
REQ-006 SHALL provide parameter X_MIN, 0, X_MAX, 711, and Y_FLOOR, 599, position bounds.
REQ-007 SHALL provide parameter GRAV_TICKS, 8, ticks per fall-velocity increment, and VMAX, 4, fall-velocity ceiling.
REQ-008 SHALL provide ports clk in 1 (clock) and rst in 1 (reset). Reset is rst: synchronous, active-high; clock is clk.
REQ-009 SHALL provide en in 1, module enable.
REQ-010 SHALL provide jump_left, jump_right and jump_fail, each in 1, single-cycle command strobes.
REQ-011 SHALL provide pos_x out COORD_W and pos_y out COORD_W, registered position.
REQ-012 SHALL provide mirror out 1 (sprite faces left), fly out 1 (airborne sprite select) and busy out 1 (not IDLE).
REQ-013 SHALL provide landed out 1, one-cycle pulse at end of motion.

Function
REQ-014 SHALL run a free-running tick counter 0..TICK_DIV-1 while en=1, asserting an internal tick on the cycle the count equals TICK_DIV-1.
REQ-015 SHALL implement the states IDLE, JUMP and FALL.
REQ-016 SHALL sample strobes only in IDLE with priority jump_fail > jump_left > jump_right, and enter FALL or JUMP on the next clock edge.
REQ-017 SHALL ignore all strobes in JUMP and FALL; they are neither queued nor counted.
REQ-018 On jump acceptance, SHALL latch the direction, set mirror (left=1, right=0), clear the step counter and set fly=1 and busy=1 from the state-entry cycle.
REQ-019 On fall acceptance, SHALL leave mirror unchanged, set vy=1 and clear the tick-in-fall counter.
REQ-020 JUMP, per tick: SHALL update x by +JUMP_DX (right) or -JUMP_DX (left), saturated to [X_MIN, X_MAX].
REQ-021 JUMP, per tick: SHALL update y by -JUMP_DY when step<JUMP_STEPS/2, otherwise by +JUMP_DY, saturated to [0, Y_FLOOR], then increment step.
REQ-022 JUMP SHALL end on the tick where step==JUMP_STEPS-1: the move is applied, the state returns to IDLE, fly=0 and landed=1 for one cycle.
REQ-023 FALL, per tick: SHALL apply y += vy saturated at Y_FLOOR, with x unchanged.
REQ-024 FALL SHALL increment vy after every GRAV_TICKS ticks, saturating at VMAX.
REQ-025 FALL SHALL end on the tick whose update yields y==Y_FLOOR: IDLE, fly=0, landed pulse; pos_y stays at Y_FLOOR.
REQ-026 Saturation SHALL be computed at COORD_W+1 bits so no wrap-around ever reaches pos_x or pos_y.
REQ-027 Position changes SHALL occur only on tick cycles; no motion takes place in IDLE.
REQ-028 landed SHALL never be asserted in the same cycle that a new command is accepted; a strobe arriving in the landed cycle is accepted, since the state is already IDLE.

Reset
REQ-029 On rst=1 or en=0, SHALL set pos_x=START_X, pos_y=START_Y, state IDLE, mirror=0, fly=0, busy=0, landed=0, tick counter 0, and step and vy 0.
REQ-030 Reset or en deassertion mid-motion SHALL abort the motion with no landed pulse; operation resumes from home in the first cycle after release.

Verification
Bench parameters: TICK_DIV=4, JUMP_STEPS=8, JUMP_DX=1, JUMP_DY=2, START_X=100, START_Y=50, X_MIN=0, X_MAX=200, Y_FLOOR=60, GRAV_TICKS=2, VMAX=3.
REQ-031 Right-jump scenario: pulse jump_right -> busy=1 and fly=1; y after ticks 1..8 is 48, 46, 44, 42, 44, 46, 48, 50; x ends at 108; mirror=0; landed for exactly 1 cycle; busy=0.
REQ-032 Left-jump scenario: pulse jump_left -> mirror=1, x ends at 92, y ends at 50. Bench variant with X_MAX=103: a right jump saturates at x=103.
REQ-033 Fall scenario: pulse jump_fail -> y per tick is 51, 52, 54, 56, 59, 60; landed on tick 6; mirror unchanged.
REQ-034 Priority/ignore scenario: jump_fail, jump_left and jump_right together -> FALL. jump_left pulsed mid-jump -> ignored, trajectory unchanged.
REQ-035 Abort scenario: rst after jump tick 3 -> next cycle pos=(100,50), busy=0, no landed. Repeat with en=0 -> same result.
REQ-036 Tick-alignment scenario: pos is never seen to change on a non-tick cycle; the landed pulse immediately followed by jump_right -> a new jump starts with no dead tick.

Source files
------------

// File: rtl/char_motion_ctrl.sv
// Character motion controller: tick-paced jump arcs and gravity falls
// with saturating coordinates, driven by single-cycle command strobes.
module char_motion_ctrl #(
    parameter int unsigned COORD_W    = 10,
    parameter int unsigned TICK_DIV   = 65000,
    parameter int unsigned START_X    = 355,
    parameter int unsigned START_Y    = 454,
    parameter int unsigned JUMP_STEPS = 80,
    parameter int unsigned JUMP_DX    = 1,
    parameter int unsigned JUMP_DY    = 2,
    parameter int unsigned X_MIN      = 0,
    parameter int unsigned X_MAX      = 711,
    parameter int unsigned Y_FLOOR    = 599,
    parameter int unsigned GRAV_TICKS = 8,
    parameter int unsigned VMAX       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               jump_left,
    input  logic               jump_right,
    input  logic               jump_fail,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               mirror,
    output logic               fly,
    output logic               busy,
    output logic               landed
);

    localparam int unsigned CW1    = COORD_W + 1;
    localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned STEP_W = (JUMP_STEPS > 1) ? $clog2(JUMP_STEPS) : 1;
    localparam int unsigned VY_W   = $clog2(VMAX + 1);
    localparam int unsigned GC_W   = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;

    typedef enum logic [1:0] {IDLE, JUMP, FALL} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tick_cnt;
    logic                tick;
    logic                dir_left_q, dir_left_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [VY_W-1:0]     vy_q, vy_d;
    logic [GC_W-1:0]     gcnt_q, gcnt_d;
    logic [COORD_W-1:0]  pos_x_d, pos_y_d;
    logic                mirror_d, fly_d, busy_d, landed_d;
    logic [CW1-1:0]      x_w, y_w, x_inc, x_dec, y_up, y_dn, y_fall;

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign x_w  = {1'b0, pos_x};
    assign y_w  = {1'b0, pos_y};

    // Free-running movement tick divider, held at zero while disabled
    always_ff @(posedge clk) begin
        if (rst || !en)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    // Saturating candidate coordinates, one bit wider so nothing wraps
    always_comb begin
        x_inc = x_w + CW1'(JUMP_DX);
        if (x_inc > CW1'(X_MAX))
            x_inc = CW1'(X_MAX);
        if (x_w < CW1'(X_MIN) + CW1'(JUMP_DX))
            x_dec = CW1'(X_MIN);
        else
            x_dec = x_w - CW1'(JUMP_DX);
        if (y_w < CW1'(JUMP_DY))
            y_up = '0;
        else
            y_up = y_w - CW1'(JUMP_DY);
        y_dn = y_w + CW1'(JUMP_DY);
        if (y_dn > CW1'(Y_FLOOR))
            y_dn = CW1'(Y_FLOOR);
        y_fall = y_w + CW1'(vy_q);
        if (y_fall > CW1'(Y_FLOOR))
            y_fall = CW1'(Y_FLOOR);
    end

    // State and registered outputs; disable acts like reset and returns home
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state_q    <= IDLE;
            pos_x      <= COORD_W'(START_X);
            pos_y      <= COORD_W'(START_Y);
            mirror     <= 1'b0;
            fly        <= 1'b0;
            busy       <= 1'b0;
            landed     <= 1'b0;
            dir_left_q <= 1'b0;
            step_q     <= '0;
            vy_q       <= '0;
            gcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            pos_x      <= pos_x_d;
            pos_y      <= pos_y_d;
            mirror     <= mirror_d;
            fly        <= fly_d;
            busy       <= busy_d;
            landed     <= landed_d;
            dir_left_q <= dir_left_d;
            step_q     <= step_d;
            vy_q       <= vy_d;
            gcnt_q     <= gcnt_d;
        end
    end

    // Next-state logic: commands only in IDLE, motion only on ticks
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x;
        pos_y_d    = pos_y;
        mirror_d   = mirror;
        fly_d      = fly;
        busy_d     = busy;
        landed_d   = 1'b0;
        dir_left_d = dir_left_q;
        step_d     = step_q;
        vy_d       = vy_q;
        gcnt_d     = gcnt_q;
        unique case (state_q)
            IDLE: begin
                if (jump_fail) begin
                    state_d = FALL;
                    vy_d    = VY_W'(1);
                    gcnt_d  = '0;
                    fly_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (jump_left || jump_right) begin
                    state_d    = JUMP;
                    dir_left_d = jump_left;
                    mirror_d   = jump_left;
                    step_d     = '0;
                    fly_d      = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            JUMP: begin
                if (tick) begin
                    pos_x_d = dir_left_q ? COORD_W'(x_dec) : COORD_W'(x_inc);
                    pos_y_d = (step_q < STEP_W'(JUMP_STEPS / 2)) ? COORD_W'(y_up)
                                                                  : COORD_W'(y_dn);
                    step_d  = step_q + STEP_W'(1);
                    if (step_q == STEP_W'(JUMP_STEPS - 1)) begin
                        state_d  = IDLE;
                        step_d   = '0;
                        fly_d    = 1'b0;
                        busy_d   = 1'b0;
                        landed_d = 1'b1;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    pos_y_d = COORD_W'(y_fall);
                    if (gcnt_q == GC_W'(GRAV_TICKS - 1)) begin
                        gcnt_d = '0;
                        if (vy_q < VY_W'(VMAX))
                            vy_d = vy_q + VY_W'(1);
                    end else begin
                        gcnt_d = gcnt_q + GC_W'(1);
                    end
                    if (y_fall == CW1'(Y_FLOOR)) begin
                        state_d  = IDLE;
                        vy_d     = '0;
                        gcnt_d   = '0;
                        fly_d    = 1'b0;
                        busy_d   = 1'b0;
                        landed_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
